fft_agu_pipelined: RTL and testbench

Parametrised, runtime-sized address generation unit for the radix-2 in-place FFT datapath. It sequences butterflies for all stages of a transform of size 2^log2_n (up to 2^MAX_LOG2). It issues read addresses and twiddle indices under a valid/ready handshake, and replays matching write addresses after the fixed butterfly latency. It sits between the FFT controller and the ping-pong sample banks and drains the butterfly pipeline before each bank swap.

---
 rtl/fft_agu_if.sv | 31 +++
 rtl/fft_agu_pipelined.sv | 122 ++++++++++++
 tb/tb_fft_agu_pipelined.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fft_agu_if.sv
// fft_agu_if: controller/datapath bundle of the FFT address generation unit
interface fft_agu_if #(
  parameter int MAX_LOG2 = 10
);
  logic                              start;
  logic [$clog2(MAX_LOG2+1)-1:0]     log2_n;
  logic                              rd_valid;
  logic                              rd_ready;
  logic [MAX_LOG2-1:0]               rd_addr_a;
  logic [MAX_LOG2-1:0]               rd_addr_b;
  logic [MAX_LOG2-2:0]               tw_idx;
  logic [$clog2(MAX_LOG2)-1:0]       stage;
  logic                              bank_sel;
  logic                              wr_valid;
  logic [MAX_LOG2-1:0]               wr_addr_a;
  logic [MAX_LOG2-1:0]               wr_addr_b;
  logic                              wr_bank;
  logic                              busy;
  logic                              done;
  logic                              cfg_err;
  modport master (
    input  start, log2_n, rd_ready,
    output rd_valid, rd_addr_a, rd_addr_b, tw_idx, stage, bank_sel,
           wr_valid, wr_addr_a, wr_addr_b, wr_bank, busy, done, cfg_err
  );
  modport slave (
    output start, log2_n, rd_ready,
    input  rd_valid, rd_addr_a, rd_addr_b, tw_idx, stage, bank_sel,
           wr_valid, wr_addr_a, wr_addr_b, wr_bank, busy, done, cfg_err
  );
endinterface

// File: rtl/fft_agu_pipelined.sv
// fft_agu_pipelined: radix-2 in-place FFT butterfly address generator; define FFT_AGU_BITREV_EN for bit-reversed stage-0 reads
module fft_agu_pipelined #(
  parameter int MAX_LOG2 = 10,
  parameter int BFLY_LAT = 4
) (
  input logic       clk,
  input logic       rst_n,
  fft_agu_if.master bus
);
  localparam int AW = MAX_LOG2;
  localparam int LW = $clog2(MAX_LOG2 + 1);
  localparam int SW = $clog2(MAX_LOG2);
  localparam int DW = $clog2(BFLY_LAT + 1);
  localparam logic [SW-1:0] TOP = SW'(MAX_LOG2 - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] n_q;
  logic [SW-1:0] stage;
  logic [AW-1:0] grp, j, stride, grp_last, nat_a, nat_b, out_a, out_b;
  logic [DW-1:0] dcnt;
  logic bank_sel, cfg_err, fire, last_j, last, legal, go, drain_end, more;
  logic [BFLY_LAT-1:0] dv, dbk;
  logic [BFLY_LAT-1:0][AW-1:0] da, db;
  assign legal     = bus.log2_n != '0 && bus.log2_n <= LW'(MAX_LOG2);
  assign go        = state == IDLE && bus.start;
  assign fire      = state == RUN && bus.rd_ready;
  assign stride    = AW'(1) << stage;
  assign grp_last  = (AW'(1) << (n_q - LW'(1) - LW'(stage))) - AW'(1);
  assign last_j    = j == stride - AW'(1);
  assign last      = last_j && grp == grp_last;
  assign more      = LW'(stage) < n_q - LW'(1);
  assign drain_end = state == DRAIN && dcnt == DW'(BFLY_LAT - 1);
  assign nat_a     = (grp << ((SW+1)'(stage) + (SW+1)'(1))) + j;
  assign nat_b     = nat_a + stride;
`ifdef FFT_AGU_BITREV_EN
  // reverse all AW bits, then drop the unused low bits to reverse over log2_n
  function automatic logic [AW-1:0] brev(input logic [AW-1:0] x, input logic [LW-1:0] n);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
    return r >> (LW'(MAX_LOG2) - n);
  endfunction
  assign out_a = stage == '0 ? brev(nat_a, n_q) : nat_a;
  assign out_b = stage == '0 ? brev(nat_b, n_q) : nat_b;
`else
  assign out_a = nat_a;
  assign out_b = nat_b;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = go && legal ? RUN : IDLE;
      RUN:   state_n = fire && last ? DRAIN : RUN;
      DRAIN: state_n = drain_end ? (more ? RUN : DONE) : DRAIN;
      DONE:  state_n = bus.start ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n_q      <= '0;
      stage    <= '0;
      grp      <= '0;
      j        <= '0;
      bank_sel <= 1'b0;
      dcnt     <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= go && !legal;
      dcnt    <= state == DRAIN ? dcnt + DW'(1) : '0;
      if (go && legal) begin
        n_q      <= bus.log2_n;
        stage    <= '0;
        grp      <= '0;
        j        <= '0;
        bank_sel <= 1'b0;
      end
      if (fire) begin
        j   <= last_j ? '0 : j + AW'(1);
        grp <= last_j ? grp + AW'(1) : grp;
      end
      if (drain_end && more) begin
        stage    <= stage + SW'(1);
        grp      <= '0;
        j        <= '0;
        bank_sel <= ~bank_sel;
      end
    end
  // write-side delay line shifts every cycle so stalls never stretch the butterfly latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dv  <= '0;
      dbk <= '0;
      da  <= '0;
      db  <= '0;
    end else begin
      dv[0]  <= fire;
      da[0]  <= fire ? nat_a : '0;
      db[0]  <= fire ? nat_b : '0;
      dbk[0] <= fire & ~bank_sel;
      for (int i = 1; i < BFLY_LAT; i++) begin
        dv[i]  <= dv[i-1];
        da[i]  <= da[i-1];
        db[i]  <= db[i-1];
        dbk[i] <= dbk[i-1];
      end
    end
  assign bus.rd_valid  = state == RUN;
  assign bus.rd_addr_a = state == RUN ? out_a : '0;
  assign bus.rd_addr_b = state == RUN ? out_b : '0;
  assign bus.tw_idx    = state == RUN ? (AW-1)'(j << (TOP - stage)) : '0;
  assign bus.stage     = stage;
  assign bus.bank_sel  = bank_sel;
  assign bus.wr_valid  = dv[BFLY_LAT-1];
  assign bus.wr_addr_a = da[BFLY_LAT-1];
  assign bus.wr_addr_b = db[BFLY_LAT-1];
  assign bus.wr_bank   = dbk[BFLY_LAT-1];
  assign bus.busy      = state == RUN || state == DRAIN;
  assign bus.done      = state == DONE;
  assign bus.cfg_err   = cfg_err;
endmodule

// File: tb/tb_fft_agu_pipelined.sv
// tb_fft_agu_pipelined: self-checking bench for fft_agu_pipelined against a butterfly-list reference model
module tb_fft_agu_pipelined;
  localparam int ML  = 10;
  localparam int LAT = 4;
`ifdef FFT_AGU_BITREV_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  typedef struct {int a; int b; int tw; int s;} bf_t;
  typedef struct {int cyc; int a; int b; int bk;} wr_t;
  typedef struct {int n; int mode; int err; int base;} vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int nchk = 0;
  int nerr = 0;
  vec_t tv[10];
  fft_agu_if #(.MAX_LOG2(ML)) bus ();
  fft_agu_pipelined #(.MAX_LOG2(ML), .BFLY_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int brev(int x, int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction
  function automatic int rd_exp(int a, int s, int n);
    return (BR && s == 0) ? brev(a, n) : a;
  endfunction
  task automatic illegal_start(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.log2_n = 4'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("cfg_err_pulse", bus.cfg_err, 1);
    chk("cfg_err_busy", {bus.busy, bus.rd_valid}, 0);
    @(negedge clk);
    chk("cfg_err_clear", bus.cfg_err, 0);
    chk("cfg_err_idle", {bus.busy, bus.rd_valid, bus.done}, 0);
  endtask
  // mode 0: always ready, 1: random ready, 2: repeating 1,0,0,1
  task automatic run_xform(input int n, input int mode, input int base);
    bf_t rq[$];
    wr_t wq[$];
    bf_t e;
    logic [3:0] pat = 4'b1001;
    int cyc = 0, busy_cnt = 0, stalls = 0, prev_s = -1, budget;
    bit seen_done = 1'b0;
    for (int s = 0; s < n; s++)
      for (int g = 0; g < (1 << (n - 1 - s)); g++)
        for (int jj = 0; jj < (1 << s); jj++) begin
          e.a = g * (2 << s) + jj;
          e.b = e.a + (1 << s);
          e.tw = jj * (1 << (ML - 1 - s));
          e.s = s;
          rq.push_back(e);
        end
    budget = 4 * n * ((1 << (n - 1)) + LAT) + 50;
    @(negedge clk);
    bus.start = 1'b1;
    bus.log2_n = 4'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_to_read", bus.rd_valid, 1);
    while (!seen_done && cyc < budget) begin
      if (cyc > 0) @(negedge clk);
      bus.log2_n = 4'($urandom_range(0, 15));
      bus.rd_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      if (bus.busy) busy_cnt++;
      if (bus.rd_valid) begin
        if (rq.size() == 0) chk("spurious_read", bus.rd_valid, 0);
        else begin
          e = rq[0];
          if (e.s != prev_s) begin
            chk("swap_writes_drained", wq.size(), 0);
            prev_s = e.s;
          end
          chk("rd_addr_a", bus.rd_addr_a, rd_exp(e.a, e.s, n));
          chk("rd_addr_b", bus.rd_addr_b, rd_exp(e.b, e.s, n));
          chk("tw_idx", bus.tw_idx, e.tw);
          chk("stage", bus.stage, e.s);
          chk("bank_sel", bus.bank_sel, e.s % 2);
          if (bus.rd_ready) begin
            wq.push_back('{cyc + LAT, e.a, e.b, 1 - e.s % 2});
            void'(rq.pop_front());
          end else stalls++;
        end
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        chk("wr_valid", bus.wr_valid, 1);
        chk("wr_addr_a", bus.wr_addr_a, wq[0].a);
        chk("wr_addr_b", bus.wr_addr_b, wq[0].b);
        chk("wr_bank", bus.wr_bank, wq[0].bk);
        void'(wq.pop_front());
      end else chk("wr_quiet", bus.wr_valid, 0);
      if (bus.done) seen_done = 1'b1;
      cyc++;
    end
    chk("done_seen", seen_done, 1);
    chk("busy_cycles", busy_cnt, base + stalls);
    chk("reads_left", rq.size(), 0);
    chk("writes_left", wq.size(), 0);
    @(negedge clk);
    chk("done_to_idle", {bus.done, bus.busy}, 0);
  endtask
  initial begin
    int cnt, n;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.log2_n = '0;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd", {bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx}, 0);
    chk("rst_wr", {bus.wr_valid, bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank}, 0);
    chk("rst_status", {bus.stage, bus.bank_sel, bus.busy, bus.done, bus.cfg_err}, 0);
    rst_n = 1'b1;
    tv = '{'{0, 0, 1, 0}, '{3, 0, 0, 24}, '{3, 2, 0, 24}, '{1, 0, 0, 5}, '{2, 1, 0, 12},
           '{11, 0, 1, 0}, '{4, 1, 0, 48}, '{5, 2, 0, 100}, '{6, 1, 0, 216}, '{10, 0, 0, 5160}};
    foreach (tv[k]) begin
      if (tv[k].err != 0) illegal_start(tv[k].n);
      else run_xform(tv[k].n, tv[k].mode, tv[k].base);
    end
    repeat (4) begin
      n = $urandom_range(1, 7);
      run_xform(n, 1, n * ((1 << (n - 1)) + LAT));
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.log2_n = 4'd1;
    bus.rd_ready = 1'b1;
    cnt = 0;
    while (!bus.done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("held_done_reached", bus.done, 1);
    repeat (5) begin
      @(negedge clk);
      chk("held_no_retrigger", {bus.done, bus.busy, bus.rd_valid}, 3'b100);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("held_release", bus.done, 0);
    bus.start = 1'b1;
    bus.log2_n = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_reset_bank", {bus.bank_sel, bus.busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {bus.rd_valid, bus.wr_valid, bus.busy, bus.bank_sel, bus.stage}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_quiet", {bus.wr_valid, bus.busy}, 0);
    end
    run_xform(4, 1, 48);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
